hazard_ctrl: RTL and testbench

Parametrised, stateful hazard-detection and pipeline-control unit for the 5-stage pipeline. It sits beside the decode stage. From the decode-stage operands, the execute-stage load, taken branches, ret/rti, and interrupt requests, it generates PC/IF-ID stall, ID-EX bubble, and buffer-flush controls. Unlike a purely combinational detector, it owns the multi-cycle stall/flush sequencing with internal counters and latches interrupt requests until they can be serviced.

---
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Decode-side hazard/pipeline control: load-use stalls, ret/rti flushes, interrupt entry.
// Zero-cycle response from registered state + inputs; no backpressure, frozen-pipeline events are ignored.
module hazard_ctrl #(
  parameter int REG_W      = 3,
  parameter int LOAD_STALL = 1,
  parameter int INT_STALL  = 2,
  parameter int RET_FLUSH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_src_valid,
  input  logic [REG_W-1:0] id_src,
  input  logic             id_dst_valid,
  input  logic [REG_W-1:0] id_dst,
  input  logic             ex_mem_read,
  input  logic             ex_wr_en,
  input  logic [REG_W-1:0] ex_wr_addr,
  input  logic             branch_taken,
  input  logic             ret,
  input  logic             int_req,
  output logic             pc_stall,
  output logic             fd_stall,
  output logic             de_bubble,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             int_ack,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LSTALL = 2'd1,
    ISTALL = 2'd2,
    RFLUSH = 2'd3
  } state_t;

  // Counter loads hold the remaining cycles after the IDLE cycle that starts the sequence.
  localparam logic [3:0] LOAD_CNT = 4'(LOAD_STALL - 1);
  localparam logic [3:0] INT_CNT  = 4'(INT_STALL - 1);
  localparam logic [3:0] RET_CNT  = 4'(RET_FLUSH - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       int_pend, int_pend_nxt;
  logic       load_use;

  assign load_use = ex_mem_read & ex_wr_en &
                    ((id_src_valid & (ex_wr_addr == id_src)) |
                     (id_dst_valid & (ex_wr_addr == id_dst)));

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    int_pend_nxt = int_pend | int_req;
    pc_stall     = 1'b0;
    fd_stall     = 1'b0;
    de_bubble    = 1'b0;
    fd_flush     = 1'b0;
    de_flush     = 1'b0;
    int_ack      = 1'b0;
    busy         = 1'b0;

    if (!rst) begin
      busy = (state != IDLE);
      unique case (state)
        IDLE: begin
          if (branch_taken) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
          end else if (ret) begin
            pc_stall = 1'b1;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            if (RET_FLUSH > 1) begin
              state_nxt = RFLUSH;
              cnt_nxt   = RET_CNT;
            end
          end else if (load_use) begin
            pc_stall  = 1'b1;
            fd_stall  = 1'b1;
            de_bubble = 1'b1;
            if (LOAD_STALL > 1) begin
              state_nxt = LSTALL;
              cnt_nxt   = LOAD_CNT;
            end
          end else if (int_pend | int_req) begin
            // A request arriving in its own service cycle is consumed, not latched.
            int_ack      = 1'b1;
            pc_stall     = 1'b1;
            fd_flush     = 1'b1;
            int_pend_nxt = 1'b0;
            if (INT_STALL > 1) begin
              state_nxt = ISTALL;
              cnt_nxt   = INT_CNT;
            end
          end
        end
        LSTALL: begin
          pc_stall  = 1'b1;
          fd_stall  = 1'b1;
          de_bubble = 1'b1;
        end
        ISTALL: begin
          pc_stall = 1'b1;
          fd_flush = 1'b1;
        end
        RFLUSH: begin
          pc_stall = 1'b1;
          fd_flush = 1'b1;
          de_flush = 1'b1;
        end
        default: ;
      endcase

      if (state != IDLE) begin
        if (cnt == 4'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      int_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      int_pend <= int_pend_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance and a reconfigured instance share stimulus.
// Observed vector order: {pc_stall, fd_stall, de_bubble, fd_flush, de_flush, int_ack, busy}.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_src_valid;
  logic [2:0] id_src;
  logic       id_dst_valid;
  logic [2:0] id_dst;
  logic       ex_mem_read;
  logic       ex_wr_en;
  logic [2:0] ex_wr_addr;
  logic       branch_taken;
  logic       ret;
  logic       int_req;

  logic d_pc_stall, d_fd_stall, d_de_bubble, d_fd_flush, d_de_flush, d_int_ack, d_busy;
  logic c_pc_stall, c_fd_stall, c_de_bubble, c_fd_flush, c_de_flush, c_int_ack, c_busy;
  logic [6:0] d_obs, c_obs;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] LDS   = 7'b1110000;
  localparam logic [6:0] LDS_B = 7'b1110001;
  localparam logic [6:0] RETF  = 7'b1001100;
  localparam logic [6:0] RET_B = 7'b1001101;
  localparam logic [6:0] ACK   = 7'b1001010;
  localparam logic [6:0] IST_B = 7'b1001001;
  localparam logic [6:0] BR    = 7'b0001100;

  hazard_ctrl #(.REG_W(3), .LOAD_STALL(1), .INT_STALL(2), .RET_FLUSH(3)) u_dflt (
    .clk(clk), .rst(rst),
    .id_src_valid(id_src_valid), .id_src(id_src),
    .id_dst_valid(id_dst_valid), .id_dst(id_dst),
    .ex_mem_read(ex_mem_read), .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
    .branch_taken(branch_taken), .ret(ret), .int_req(int_req),
    .pc_stall(d_pc_stall), .fd_stall(d_fd_stall), .de_bubble(d_de_bubble),
    .fd_flush(d_fd_flush), .de_flush(d_de_flush), .int_ack(d_int_ack), .busy(d_busy)
  );

  hazard_ctrl #(.REG_W(3), .LOAD_STALL(3), .INT_STALL(3), .RET_FLUSH(1)) u_cfg (
    .clk(clk), .rst(rst),
    .id_src_valid(id_src_valid), .id_src(id_src),
    .id_dst_valid(id_dst_valid), .id_dst(id_dst),
    .ex_mem_read(ex_mem_read), .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
    .branch_taken(branch_taken), .ret(ret), .int_req(int_req),
    .pc_stall(c_pc_stall), .fd_stall(c_fd_stall), .de_bubble(c_de_bubble),
    .fd_flush(c_fd_flush), .de_flush(c_de_flush), .int_ack(c_int_ack), .busy(c_busy)
  );

  assign d_obs = {d_pc_stall, d_fd_stall, d_de_bubble, d_fd_flush, d_de_flush, d_int_ack, d_busy};
  assign c_obs = {c_pc_stall, c_fd_stall, c_de_bubble, c_fd_flush, c_de_flush, c_int_ack, c_busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr();
    id_src_valid = 1'b0; id_src = 3'd0;
    id_dst_valid = 1'b0; id_dst = 3'd0;
    ex_mem_read  = 1'b0; ex_wr_en = 1'b0; ex_wr_addr = 3'd0;
    branch_taken = 1'b0; ret = 1'b0; int_req = 1'b0;
  endtask

  task automatic load_src(input logic [2:0] addr);
    ex_mem_read = 1'b1; ex_wr_en = 1'b1; ex_wr_addr = addr;
    id_src_valid = 1'b1; id_src = addr;
  endtask

  // Sample mid-cycle on the falling edge, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [6:0] exp_d, input logic [6:0] exp_c);
    @(negedge clk);
    total++;
    assert (d_obs === exp_d) else begin
      bad++;
      $error("FAIL %s dflt observed=%b expected=%b", tag, d_obs, exp_d);
    end
    total++;
    assert (c_obs === exp_c) else begin
      bad++;
      $error("FAIL %s cfg observed=%b expected=%b", tag, c_obs, exp_c);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    branch_taken = 1'b1; int_req = 1'b1; load_src(3'd2);
    step("rst_hold", NONE, NONE);
    rst = 1'b0; clr();
    step("post_rst", NONE, NONE);

    // Load-use on id_src: dflt stalls 1 cycle, cfg 3 cycles.
    load_src(3'd3);
    step("lu_src_c1", LDS, LDS);
    clr();
    step("lu_src_c2", NONE, LDS_B);
    step("lu_src_c3", NONE, LDS_B);
    step("lu_src_c4", NONE, NONE);

    // Non-matching cases.
    load_src(3'd3); id_src_valid = 1'b0; id_dst = 3'd3;
    step("lu_no_valid", NONE, NONE);
    load_src(3'd3); id_src = 3'd2;
    step("lu_addr_diff", NONE, NONE);
    load_src(3'd3); ex_wr_en = 1'b0;
    step("lu_no_wr", NONE, NONE);
    clr();

    // Load-use matched on id_dst=5.
    ex_mem_read = 1'b1; ex_wr_en = 1'b1; ex_wr_addr = 3'd5;
    id_dst_valid = 1'b1; id_dst = 3'd5;
    step("lu_dst_c1", LDS, LDS);
    clr();
    step("lu_dst_c2", NONE, LDS_B);
    step("lu_dst_c3", NONE, LDS_B);
    step("lu_dst_c4", NONE, NONE);

    // Load-use on register 0 is an ordinary match.
    load_src(3'd0);
    step("lu_reg0_c1", LDS, LDS);
    clr();
    step("lu_reg0_c2", NONE, LDS_B);
    step("lu_reg0_c3", NONE, LDS_B);
    step("lu_reg0_c4", NONE, NONE);

    // ret, with int_req in cycle 2.
    ret = 1'b1;
    step("ret_c1", RETF, RETF);
    ret = 1'b0; int_req = 1'b1;
    step("ret_c2", RET_B, ACK);
    int_req = 1'b0;
    step("ret_c3", RET_B, IST_B);
    step("ret_c4", ACK, IST_B);
    step("ret_c5", IST_B, NONE);
    step("ret_c6", NONE, NONE);

    // ret outranks load_use.
    ret = 1'b1; load_src(3'd4);
    step("ret_lu_c1", RETF, RETF);
    clr();
    step("ret_lu_c2", RET_B, NONE);
    step("ret_lu_c3", RET_B, NONE);
    step("ret_lu_c4", NONE, NONE);

    // branch + load_use + int_req together: branch wins, interrupt latched.
    branch_taken = 1'b1; int_req = 1'b1; load_src(3'd6);
    step("br_all_c1", BR, BR);
    clr();
    step("br_all_c2", ACK, ACK);
    step("br_all_c3", IST_B, IST_B);
    step("br_all_c4", NONE, IST_B);
    step("br_all_c5", NONE, NONE);

    // Reset in cycle 2 of a load stall with an interrupt pending.
    load_src(3'd1); int_req = 1'b1;
    step("rst_mid_c1", LDS, LDS);
    clr(); rst = 1'b1;
    step("rst_mid_c2", NONE, NONE);
    rst = 1'b0;
    step("rst_mid_c3", NONE, NONE);
    step("rst_mid_c4", NONE, NONE);

    // Two int_req pulses inside one cfg ISTALL merge into a single later ack.
    int_req = 1'b1;
    step("int2_c1", ACK, ACK);
    step("int2_c2", IST_B, IST_B);
    step("int2_c3", ACK, IST_B);
    int_req = 1'b0;
    step("int2_c4", IST_B, ACK);
    step("int2_c5", NONE, IST_B);
    step("int2_c6", NONE, IST_B);
    step("int2_c7", NONE, NONE);
    step("int2_c8", NONE, NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
